// File: rtl/imm_encoder.sv
// Immediate encoder: scatters a 32-bit immediate into the RISC-V field positions
// of an instruction template, flags range/alignment errors, buffers results in a 2-entry FIFO.
module imm_encoder #(
  parameter int FIFO_DEPTH = 2,
  parameter int ERR_W      = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      Imm,
  input  logic [31:0]      InstrTpl,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      Instr_out,
  output logic             ImmErr,
  output logic [ERR_W-1:0] ErrCount
);

  typedef struct packed {
    logic [31:0] instr;
    logic        err;
  } entry_t;

  localparam logic [2:0] SRC_I = 3'b000;
  localparam logic [2:0] SRC_S = 3'b001;
  localparam logic [2:0] SRC_U = 3'b010;
  localparam logic [2:0] SRC_B = 3'b101;
  localparam logic [2:0] SRC_J = 3'b110;

  entry_t           enc;
  entry_t           mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q, cnt_d;
  logic [ERR_W-1:0] err_cnt_q, err_cnt_d;
  logic             push, pop;

  // A field fits when all bits above its sign bit replicate it.
  function automatic logic all_same(input logic [31:0] v, input int lo);
    logic ones, zeros;
    ones  = 1'b1;
    zeros = 1'b1;
    for (int k = 0; k < 32; k++) begin
      if (k >= lo) begin
        ones  = ones & v[k];
        zeros = zeros & ~v[k];
      end
    end
    return ones | zeros;
  endfunction

  always_comb begin
    enc.instr = InstrTpl;
    enc.err   = 1'b0;
    case (ImmSrc)
      SRC_I: begin
        enc.instr[31:20] = Imm[11:0];
        enc.err          = ~all_same(Imm, 11);
      end
      SRC_S: begin
        enc.instr[31:25] = Imm[11:5];
        enc.instr[11:7]  = Imm[4:0];
        enc.err          = ~all_same(Imm, 11);
      end
      SRC_B: begin
        enc.instr[31]    = Imm[12];
        enc.instr[30:25] = Imm[10:5];
        enc.instr[11:8]  = Imm[4:1];
        enc.instr[7]     = Imm[11];
        enc.err          = ~all_same(Imm, 12) | Imm[0];
      end
      SRC_U: begin
        enc.instr[31:12] = Imm[31:12];
        enc.err          = |Imm[11:0];
      end
      SRC_J: begin
        enc.instr[31]    = Imm[20];
        enc.instr[30:21] = Imm[10:1];
        enc.instr[20]    = Imm[11];
        enc.instr[19:12] = Imm[19:12];
        enc.err          = ~all_same(Imm, 20) | Imm[0];
      end
      default: enc.err = 1'b1;  // illegal format: template passes through untouched
    endcase
  end

  assign in_ready  = (cnt_q < 2'(FIFO_DEPTH));
  assign out_valid = (cnt_q != 2'd0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign Instr_out = mem_q[rd_q].instr;
  assign ImmErr    = mem_q[rd_q].err;
  assign ErrCount  = err_cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 2'd1;
      2'b01:   cnt_d = cnt_q - 2'd1;
      default: cnt_d = cnt_q;
    endcase
    err_cnt_d = err_cnt_q;
    if (push && enc.err && (err_cnt_q != {ERR_W{1'b1}}))
      err_cnt_d = err_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_q[0]  <= '0;
      mem_q[1]  <= '0;
      wr_q      <= 1'b0;
      rd_q      <= 1'b0;
      cnt_q     <= 2'd0;
      err_cnt_q <= '0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= enc;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_encoder.sv
// Directed bench for imm_encoder: packing/check vectors, backpressure, reset, saturation.
module tb_imm_encoder;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [2:0]  ImmSrc;
  logic [31:0] Imm, InstrTpl;
  logic        out_valid, out_ready;
  logic [31:0] Instr_out;
  logic        ImmErr;
  logic [7:0]  ErrCount;

  int n_chk  = 0;
  int n_pass = 0;

  imm_encoder #(.FIFO_DEPTH(2), .ERR_W(8)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .ImmSrc(ImmSrc), .Imm(Imm), .InstrTpl(InstrTpl),
    .out_valid(out_valid), .out_ready(out_ready),
    .Instr_out(Instr_out), .ImmErr(ImmErr), .ErrCount(ErrCount)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    string       tag;
    logic [2:0]  src;
    logic [31:0] imm;
    logic [31:0] tpl;
    logic [31:0] word;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{"I_neg1",   3'b000, 32'hFFFF_FFFF, 32'h0000_0093, 32'hFFF0_0093, 1'b0});
    vecs.push_back('{"S_neg8",   3'b001, 32'hFFFF_FFF8, 32'h0000_0023, 32'hFE00_0C23, 1'b0});
    vecs.push_back('{"B_neg4",   3'b101, 32'hFFFF_FFFC, 32'h0000_0063, 32'hFE00_0EE3, 1'b0});
    vecs.push_back('{"B_odd",    3'b101, 32'h0000_0007, 32'h0000_0063, 32'h0000_0363, 1'b1});
    vecs.push_back('{"U_ok",     3'b010, 32'h1234_5000, 32'h0000_00B7, 32'h1234_50B7, 1'b0});
    vecs.push_back('{"U_low",    3'b010, 32'h0000_0001, 32'h0000_0037, 32'h0000_0037, 1'b1});
    vecs.push_back('{"J_800",    3'b110, 32'h0000_0800, 32'h0000_00EF, 32'h0010_00EF, 1'b0});
    vecs.push_back('{"J_neg2",   3'b110, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0});
    vecs.push_back('{"I_range",  3'b000, 32'h0000_0800, 32'h0000_0093, 32'h8000_0093, 1'b1});
    vecs.push_back('{"illegal",  3'b111, 32'hDEAD_BEEF, 32'h1234_5678, 32'h1234_5678, 1'b1});

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    ImmSrc = 3'b000; Imm = '0; InstrTpl = '0;
    step(); step();
    rst = 1'b0;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("rst_instr",     Instr_out,          32'd0);
    chk("rst_immerr",    {31'd0, ImmErr},    32'd0);
    chk("rst_errcount",  {24'd0, ErrCount},  32'd0);

    // single requests with consumer always ready
    foreach (vecs[i]) begin
      in_valid = 1'b1; ImmSrc = vecs[i].src; Imm = vecs[i].imm; InstrTpl = vecs[i].tpl;
      step();
      in_valid = 1'b0;
      chk({vecs[i].tag, "_valid"}, {31'd0, out_valid}, 32'd1);
      chk({vecs[i].tag, "_word"},  Instr_out, vecs[i].word);
      chk({vecs[i].tag, "_err"},   {31'd0, ImmErr}, {31'd0, vecs[i].err});
      step();
      chk({vecs[i].tag, "_drain"}, {31'd0, out_valid}, 32'd0);
    end
    chk("errcount_after_vecs", {24'd0, ErrCount}, 32'd4);

    // backpressure: fill, stall the third, then drain with overlap
    out_ready = 1'b0; ImmSrc = 3'b000; InstrTpl = 32'h0000_0013;
    in_valid = 1'b1; Imm = 32'd1; step();
    Imm = 32'd2; step();
    chk("bp_full_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head_a", Instr_out, 32'h0010_0013);
    Imm = 32'd3; step();
    chk("bp_stall_in_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_stall_head", Instr_out, 32'h0010_0013);
    out_ready = 1'b1; step();
    chk("bp_head_b", Instr_out, 32'h0020_0013);
    chk("bp_cnt1_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    in_valid = 1'b0;
    chk("bp_head_c", Instr_out, 32'h0030_0013);
    chk("bp_pushpop_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_pushpop_in_ready", {31'd0, in_ready}, 32'd1);
    step();
    chk("bp_empty", {31'd0, out_valid}, 32'd0);

    // reset mid-stream with two entries buffered and ErrCount at 5
    out_ready = 1'b0; in_valid = 1'b1;
    ImmSrc = 3'b111; InstrTpl = 32'hCAFE_0000; step();
    ImmSrc = 3'b000; Imm = 32'd5; InstrTpl = 32'h0000_0013; step();
    in_valid = 1'b0;
    chk("mid_errcount", {24'd0, ErrCount}, 32'd5);
    chk("mid_full", {31'd0, in_ready}, 32'd0);
    rst = 1'b1; step();
    rst = 1'b0;
    chk("mrst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_in_ready",  {31'd0, in_ready},  32'd1);
    chk("mrst_errcount",  {24'd0, ErrCount},  32'd0);
    chk("mrst_instr",     Instr_out,          32'd0);

    // saturation: 260 back-to-back erroneous accepts
    out_ready = 1'b1; in_valid = 1'b1; ImmSrc = 3'b011; InstrTpl = 32'h0000_0013;
    for (int k = 1; k <= 260; k++) begin
      step();
      if (k == 254) chk("sat_254", {24'd0, ErrCount}, 32'd254);
      if (k == 255) chk("sat_255", {24'd0, ErrCount}, 32'd255);
    end
    in_valid = 1'b0;
    chk("sat_260", {24'd0, ErrCount}, 32'd255);
    chk("sat_err_flag", {31'd0, ImmErr}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
